// File: rtl/generador_pulso_pkg.sv
// Shared types and sizing helpers for the one-shot pulse generator.
package generador_pulso_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ALTO   = 2'd1,
    PAUSA  = 2'd2
  } estado_t;

  localparam int ANCHO_W_DEF  = 8;
  localparam int PEND_MAX_DEF = 3;

  // Width of the queued-trigger counter for a given saturation value.
  function automatic int pend_w(input int pend_max);
    return $clog2(pend_max + 1);
  endfunction

endpackage

// File: rtl/generador_pulso_if.sv
// Trigger/config inputs and level/status outputs of the pulse generator.
interface generador_pulso_if
  import generador_pulso_pkg::*;
#(
  parameter int ANCHO_W  = ANCHO_W_DEF,
  parameter int PEND_MAX = PEND_MAX_DEF
) ();

  logic                        disparo;
  logic [ANCHO_W-1:0]          ancho;
  logic [ANCHO_W-1:0]          separacion;
  logic                        senal_salida;
  logic                        ocupado;
  logic                        perdido;
  logic [pend_w(PEND_MAX)-1:0] pendientes;

  modport master (
    output disparo, ancho, separacion,
    input  senal_salida, ocupado, perdido, pendientes
  );

  modport slave (
    input  disparo, ancho, separacion,
    output senal_salida, ocupado, perdido, pendientes
  );

endinterface

// File: rtl/generador_pulso_contador_descendente.sv
// Loadable down-counter; terminal flags the last cycle of a load (count == 1).
module contador_descendente #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic         terminal
);

  logic [W-1:0] cuenta;

  // Load wins over decrement; the count parks at zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cuenta <= '0;
    else if (carga)        cuenta <= valor;
    else if (cuenta != '0) cuenta <= cuenta - 1'b1;
  end

  assign terminal = (cuenta == W'(1));

endmodule

// File: rtl/generador_pulso.sv
// One-shot pulse generator: high for max(ancho,1) cycles, then a separacion
// low gap. Optional trigger queue under GENERADOR_PULSO_COLA_EN.
module generador_pulso
  import generador_pulso_pkg::*;
#(
  parameter int ANCHO_W  = ANCHO_W_DEF,
  parameter int PEND_MAX = PEND_MAX_DEF
) (
  input logic             clk,
  input logic             rst_n,
  generador_pulso_if.slave bus
);

  localparam int PW = pend_w(PEND_MAX);

  estado_t            estado, estado_n;
  logic [ANCHO_W-1:0] valor_carga, ancho_ef;
  logic               carga, terminal;
  logic [PW-1:0]      pend;
  logic               hay_pend, fin, inicio, toma_cola, encola_req, descarta;
  logic               sal_q, perdido_q;

  contador_descendente #(.W(ANCHO_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .carga    (carga),
    .valor    (valor_carga),
    .terminal (terminal)
  );

  // Start arbitration and next-state decode; queued starts beat a fresh disparo.
  always_comb begin
    hay_pend    = (pend != '0);
    ancho_ef    = (bus.ancho == '0) ? ANCHO_W'(1) : bus.ancho;
    fin         = terminal && ((estado == ALTO && bus.separacion == '0) || estado == PAUSA);
    inicio      = ((estado == REPOSO) || fin) && (bus.disparo || hay_pend);
    toma_cola   = inicio && hay_pend;
    // disparo not consumed as a direct start must go to the queue (or be lost)
    encola_req  = bus.disparo && !(inicio && !hay_pend);
    estado_n    = estado;
    carga       = 1'b0;
    valor_carga = ancho_ef;
    case (estado)
      REPOSO: if (inicio) begin
        estado_n = ALTO;
        carga    = 1'b1;
      end
      ALTO: if (terminal) begin
        if (bus.separacion != '0) begin
          estado_n    = PAUSA;
          carga       = 1'b1;
          valor_carga = bus.separacion;
        end else if (inicio) begin
          carga = 1'b1;
        end else begin
          estado_n = REPOSO;
        end
      end
      PAUSA: if (terminal) begin
        if (inicio) begin
          estado_n = ALTO;
          carga    = 1'b1;
        end else begin
          estado_n = REPOSO;
        end
      end
      default: estado_n = REPOSO;
    endcase
  end

`ifdef GENERADOR_PULSO_COLA_EN
  logic lleno;
  assign lleno    = (pend == PW'(PEND_MAX));
  assign descarta = encola_req && lleno && !toma_cola;

  // Saturating queue count; simultaneous enqueue and dequeue cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else begin
      case ({encola_req && !descarta, toma_cola})
        2'b10:   pend <= pend + PW'(1);
        2'b01:   pend <= pend - PW'(1);
        default: pend <= pend;
      endcase
    end
  end
`else
  assign pend     = '0;
  assign descarta = encola_req;
`endif

  // State, registered output level and one-cycle loss flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= REPOSO;
      sal_q     <= 1'b0;
      perdido_q <= 1'b0;
    end else begin
      estado    <= estado_n;
      sal_q     <= (estado_n == ALTO);
      perdido_q <= descarta;
    end
  end

  assign bus.senal_salida = sal_q;
  assign bus.ocupado      = (estado != REPOSO);
  assign bus.perdido      = perdido_q;
  assign bus.pendientes   = pend;

endmodule
